// File: rtl/vga_ctrl_regs.sv
// AXI4-Lite slave register bank for the VGA controller: byte-strobed writable
// control words, read-only status words and a per-register write pulse.
module vga_ctrl_regs #(
  parameter int                    C_NUM_REGS   = 8,
  parameter int                    C_ADDR_WIDTH = 6,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0,
  parameter logic [31:0]           C_RESET_VAL  = 32'h0000_0000
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]    AWADDR,
  input  logic [2:0]                 AWPROT,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [31:0]                WDATA,
  input  logic [3:0]                 WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [C_ADDR_WIDTH-1:0]    ARADDR,
  input  logic [2:0]                 ARPROT,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [31:0]                RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [32*C_NUM_REGS-1:0]   reg_out,
  input  logic [32*C_NUM_REGS-1:0]   status_in,
  output logic [C_NUM_REGS-1:0]      wr_pulse
);

  localparam int         IDX_W       = C_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  run_r;
  logic                  awready_r;
  logic                  bvalid_r;
  logic [1:0]            bresp_r;
  logic [C_NUM_REGS-1:0] wr_pulse_r;
  logic                  arready_r;
  logic                  rvalid_r;
  logic [1:0]            rresp_r;
  logic [31:0]           rdata_r;
  logic [31:0]           regs_r [C_NUM_REGS];

  logic [IDX_W-1:0]      aw_idx_s;
  logic [IDX_W-1:0]      ar_idx_s;
  logic [C_NUM_REGS-1:0] wr_hit_s;
  logic [C_NUM_REGS-1:0] rd_hit_s;
  logic [C_NUM_REGS-1:0] wr_sel_s;
  logic [31:0]           rd_word_s [C_NUM_REGS];
  logic [31:0]           rd_data_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic                  unused_s;

  assign aw_idx_s = AWADDR[C_ADDR_WIDTH-1:2];
  assign ar_idx_s = ARADDR[C_ADDR_WIDTH-1:2];

  // Read-only words expose live status; their storage is never written.
  genvar g;
  generate
    for (g = 0; g < C_NUM_REGS; g++) begin : g_reg
      assign wr_hit_s[g]          = (int'(aw_idx_s) == g);
      assign rd_hit_s[g]          = (int'(ar_idx_s) == g);
      assign rd_word_s[g]         = C_RO_MASK[g] ? status_in[32*g +: 32] : regs_r[g];
      assign reg_out[32*g +: 32]  = C_RO_MASK[g] ? 32'h0000_0000 : regs_r[g];
    end
  endgenerate

  assign wr_sel_s = wr_hit_s & ~C_RO_MASK;
  assign wr_ok_s  = |wr_sel_s;
  assign rd_ok_s  = |rd_hit_s;
  assign unused_s = ^{AWADDR[1:0], ARADDR[1:0], AWPROT, ARPROT, status_in};

  // Read data mux; an out-of-range index selects nothing and yields zero
  always_comb begin
    rd_data_s = 32'h0000_0000;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      rd_data_s = rd_data_s | (rd_hit_s[i] ? rd_word_s[i] : 32'h0000_0000);
    end
  end

  // Holds off handshakes until the first edge after reset release
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Write accept, commit response and one-cycle write pulse
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_r  <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      wr_pulse_r <= '0;
    end else begin
      awready_r  <= run_r && AWVALID && WVALID && !awready_r && !bvalid_r;
      wr_pulse_r <= '0;
      if (awready_r) begin
        bvalid_r   <= 1'b1;
        bresp_r    <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
        wr_pulse_r <= wr_sel_s;
      end else if (bvalid_r && BREADY) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Register storage with per-byte strobes
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        regs_r[i] <= C_RESET_VAL;
      end
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (awready_r && wr_sel_s[i] && WSTRB[k]) begin
            regs_r[i][8*k +: 8] <= WDATA[8*k +: 8];
          end
        end
      end
    end
  end

  // Read accept and response capture; same-edge writes are not yet visible
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= 32'h0000_0000;
    end else begin
      arready_r <= run_r && ARVALID && !arready_r && !rvalid_r;
      if (arready_r) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_data_s;
        rresp_r  <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_r && RREADY) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  assign AWREADY  = awready_r;
  assign WREADY   = awready_r;
  assign BVALID   = bvalid_r;
  assign BRESP    = bresp_r;
  assign ARREADY  = arready_r;
  assign RVALID   = rvalid_r;
  assign RRESP    = rresp_r;
  assign RDATA    = rdata_r;
  assign wr_pulse = wr_pulse_r;

endmodule

// File: tb/tb_vga_ctrl_regs.sv
// Self-checking bench for vga_ctrl_regs: 8 registers, word 7 read-only,
// scoreboard queues hold expected responses until the DUT answers.
module tb_vga_ctrl_regs;

  localparam int          NREG  = 8;
  localparam logic [31:0] RVAL  = 32'hA5A5_0F0F;
  localparam logic [1:0]  OKAY  = 2'b00;
  localparam logic [1:0]  SLV   = 2'b10;

  logic              tb_ACLK;
  logic              ARESETN;
  logic [5:0]        AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [5:0]        ARADDR;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
  logic [32*NREG-1:0] reg_out;
  logic [32*NREG-1:0] status_in;
  logic [NREG-1:0]   wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_regs [NREG];
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];

  vga_ctrl_regs #(
    .C_NUM_REGS(NREG), .C_ADDR_WIDTH(6), .C_RO_MASK(8'h80), .C_RESET_VAL(RVAL)
  ) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) begin
      if (s[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

  // Drives one write; returns the response and pulse seen right after commit.
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic [NREG-1:0] pulse);
    int n;
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
    n = 0;
    do begin @(posedge tb_ACLK); #1; n++; end while (!AWREADY && n < 20);
    if (!AWREADY) begin
      checks++; errors++;
      $display("FAIL aw_timeout addr=%h got AWREADY=%b exp 1", addr, AWREADY);
    end
    @(posedge tb_ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    resp = BRESP; pulse = wr_pulse;
    if (!BVALID) begin
      checks++; errors++;
      $display("FAIL b_timeout addr=%h got BVALID=%b exp 1", addr, BVALID);
    end
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [33:0] got);
    int n;
    ARADDR = addr; ARVALID = 1'b1;
    n = 0;
    do begin @(posedge tb_ACLK); #1; n++; end while (!ARREADY && n < 20);
    if (!ARREADY) begin
      checks++; errors++;
      $display("FAIL ar_timeout addr=%h got ARREADY=%b exp 1", addr, ARREADY);
    end
    @(posedge tb_ACLK); #1;
    ARVALID = 1'b0;
    got = {RRESP, RDATA};
    if (!RVALID) begin
      checks++; errors++;
      $display("FAIL r_timeout addr=%h got RVALID=%b exp 1", addr, RVALID);
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0; AWPROT = '0; ARPROT = '0;
    for (int i = 0; i < NREG; i++) begin
      status_in[32*i +: 32] = 32'hEEEE_0000 | 32'(i);
      exp_regs[i] = RVAL;
    end
    status_in[255:224] = 32'hCAFE_F00D;
    repeat (3) @(posedge tb_ACLK);
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, wr_pulse} !== 17'h0
        || RDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b rdata=%h exp all zero",
               {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, wr_pulse}, RDATA);
    end
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (reg_out[32*i +: 32] !== ((i == 7) ? 32'h0 : RVAL)) begin
        errors++;
        $display("FAIL reset_reg%0d got=%h exp=%h", i, reg_out[32*i +: 32],
                 (i == 7) ? 32'h0 : RVAL);
      end
    end
    @(negedge tb_ACLK); ARESETN = 1'b1;
    @(posedge tb_ACLK); #1;
  endtask

  task automatic test_defaults();
    logic [31:0] wd [4];
    logic [1:0] resp, eb;
    logic [NREG-1:0] pulse;
    logic [33:0] got, er;
    wd[0] = 32'h0101_FFFF; wd[1] = 32'hABCD_0001;
    wd[2] = 32'hDEAD_0011; wd[3] = 32'hBEEF_0011;
    for (int i = 0; i < 4; i++) begin
      exp_b_q.push_back(OKAY);
      exp_regs[i] = wd[i];
      axi_write(6'(4*i), wd[i], 4'hF, resp, pulse);
      eb = exp_b_q.pop_front();
      checks++;
      if (resp !== eb) begin
        errors++; $display("FAIL def_bresp%0d got=%b exp=%b", i, resp, eb);
      end
      checks++;
      if (pulse !== (8'h01 << i)) begin
        errors++; $display("FAIL def_pulse%0d got=%b exp=%b", i, pulse, 8'h01 << i);
      end
      @(posedge tb_ACLK); #1;
      checks++;
      if (wr_pulse !== 8'h00) begin
        errors++; $display("FAIL def_pulse_len%0d got=%b exp=0", i, wr_pulse);
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_r_q.push_back({OKAY, exp_regs[i]});
      axi_read(6'(4*i), got);
      er = exp_r_q.pop_front();
      checks++;
      if (got !== er) begin
        errors++; $display("FAIL def_read%0d got=%h exp=%h", i, got, er);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp, eb;
    logic [NREG-1:0] pulse;
    logic [33:0] got, er;
    exp_b_q.push_back(OKAY);
    exp_regs[1] = apply_strb(exp_regs[1], 32'hFFFF_FFFF, 4'hF);
    axi_write(6'h04, 32'hFFFF_FFFF, 4'hF, resp, pulse);
    eb = exp_b_q.pop_front();
    checks++;
    if (resp !== eb) begin errors++; $display("FAIL strb_b0 got=%b exp=%b", resp, eb); end
    exp_b_q.push_back(OKAY);
    exp_regs[1] = apply_strb(exp_regs[1], 32'h1234_5678, 4'b0101);
    axi_write(6'h04, 32'h1234_5678, 4'b0101, resp, pulse);
    eb = exp_b_q.pop_front();
    checks++;
    if (resp !== eb) begin errors++; $display("FAIL strb_b1 got=%b exp=%b", resp, eb); end
    exp_b_q.push_back(OKAY);
    axi_write(6'h04, 32'hDEAD_BEEF, 4'b0000, resp, pulse);
    eb = exp_b_q.pop_front();
    checks++;
    if (resp !== eb || pulse !== 8'h02) begin
      errors++; $display("FAIL strb_zero got=%b/%b exp=%b/00000010", resp, pulse, eb);
    end
    exp_r_q.push_back({OKAY, 32'hFF34_FF78});
    axi_read(6'h04, got);
    er = exp_r_q.pop_front();
    checks++;
    if (got !== er) begin errors++; $display("FAIL strb_read got=%h exp=%h", got, er); end
  endtask

  task automatic test_read_only();
    logic [1:0] resp, eb;
    logic [NREG-1:0] pulse;
    logic [33:0] got, er;
    exp_b_q.push_back(SLV);
    axi_write(6'h1C, 32'h0000_0001, 4'hF, resp, pulse);
    eb = exp_b_q.pop_front();
    checks++;
    if (resp !== eb || pulse !== 8'h00) begin
      errors++; $display("FAIL ro_write got=%b/%b exp=%b/00000000", resp, pulse, eb);
    end
    exp_r_q.push_back({OKAY, 32'hCAFE_F00D});
    axi_read(6'h1C, got);
    er = exp_r_q.pop_front();
    checks++;
    if (got !== er) begin errors++; $display("FAIL ro_read got=%h exp=%h", got, er); end
    status_in[255:224] = 32'h0BAD_CAFE;
    exp_r_q.push_back({OKAY, 32'h0BAD_CAFE});
    axi_read(6'h1C, got);
    er = exp_r_q.pop_front();
    checks++;
    if (got !== er || reg_out[255:224] !== 32'h0) begin
      errors++; $display("FAIL ro_live got=%h reg_out=%h exp=%h/0", got, reg_out[255:224], er);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp, eb;
    logic [NREG-1:0] pulse;
    logic [33:0] got, er;
    exp_b_q.push_back(SLV);
    axi_write(6'h20, 32'hFFFF_FFFF, 4'hF, resp, pulse);
    eb = exp_b_q.pop_front();
    checks++;
    if (resp !== eb || pulse !== 8'h00) begin
      errors++; $display("FAIL oor_write got=%b/%b exp=%b/00000000", resp, pulse, eb);
    end
    exp_r_q.push_back({SLV, 32'h0});
    axi_read(6'h3E, got);
    er = exp_r_q.pop_front();
    checks++;
    if (got !== er) begin errors++; $display("FAIL oor_read got=%h exp=%h", got, er); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (reg_out[32*i +: 32] !== exp_regs[i]) begin
        errors++; $display("FAIL oor_keep%0d got=%h exp=%h", i, reg_out[32*i +: 32], exp_regs[i]);
      end
    end
    exp_r_q.push_back({OKAY, exp_regs[2]});
    axi_read(6'h0B, got);
    er = exp_r_q.pop_front();
    checks++;
    if (got !== er) begin errors++; $display("FAIL low_bits got=%h exp=%h", got, er); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp, eb;
    logic [NREG-1:0] pulse;
    logic [33:0] got, er;
    int bad;
    BREADY = 1'b0;
    exp_b_q.push_back(OKAY);
    exp_regs[3] = 32'h1111_1111;
    axi_write(6'h0C, 32'h1111_1111, 4'hF, resp, pulse);
    eb = exp_b_q.pop_front();
    checks++;
    if (resp !== eb) begin errors++; $display("FAIL b2b_first got=%b exp=%b", resp, eb); end
    AWADDR = 6'h0C; WDATA = 32'h2222_2222; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge tb_ACLK); #1;
      if (BVALID !== 1'b1 || AWREADY !== 1'b0 || BRESP !== OKAY) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_hold got=%0d bad cycles exp 0", bad); end
    BREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b0) begin
      errors++; $display("FAIL b2b_release got=%b%b exp=00", BVALID, AWREADY);
    end
    ARADDR = 6'h0C; ARVALID = 1'b1;
    exp_r_q.push_back({OKAY, exp_regs[3]});
    @(posedge tb_ACLK); #1;
    checks++;
    if (AWREADY !== 1'b1 || ARREADY !== 1'b1) begin
      errors++; $display("FAIL b2b_same_edge got=%b%b exp=11", AWREADY, ARREADY);
    end
    @(posedge tb_ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    exp_regs[3] = 32'h2222_2222;
    er = exp_r_q.pop_front();
    checks++;
    if ({RRESP, RDATA} !== er || RVALID !== 1'b1 || BVALID !== 1'b1 || BRESP !== OKAY) begin
      errors++; $display("FAIL b2b_old_value got=%h r%b b%b exp=%h", {RRESP, RDATA}, RVALID, BVALID, er);
    end
    @(posedge tb_ACLK); #1;
    exp_r_q.push_back({OKAY, exp_regs[3]});
    axi_read(6'h0C, got);
    er = exp_r_q.pop_front();
    checks++;
    if (got !== er) begin errors++; $display("FAIL b2b_new_value got=%h exp=%h", got, er); end
  endtask

  task automatic test_reset_abort();
    logic [1:0] resp, eb;
    logic [NREG-1:0] pulse;
    logic [33:0] got, er;
    BREADY = 1'b0;
    exp_b_q.push_back(OKAY);
    axi_write(6'h04, 32'h3333_3333, 4'hF, resp, pulse);
    eb = exp_b_q.pop_front();
    checks++;
    if (resp !== eb) begin errors++; $display("FAIL abort_write got=%b exp=%b", resp, eb); end
    @(negedge tb_ACLK); ARESETN = 1'b0; #1;
    for (int i = 0; i < NREG; i++) exp_regs[i] = RVAL;
    checks++;
    if (BVALID !== 1'b0 || reg_out[63:32] !== RVAL) begin
      errors++; $display("FAIL abort_async got=%b/%h exp=0/%h", BVALID, reg_out[63:32], RVAL);
    end
    AWADDR = 6'h08; WDATA = 32'h7777_7777; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    repeat (2) @(negedge tb_ACLK);
    ARESETN = 1'b1; BREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    checks++;
    if (AWREADY !== 1'b0) begin errors++; $display("FAIL rel_edge1 got=%b exp=0", AWREADY); end
    @(posedge tb_ACLK); #1;
    checks++;
    if (AWREADY !== 1'b1) begin errors++; $display("FAIL rel_edge2 got=%b exp=1", AWREADY); end
    exp_b_q.push_back(OKAY);
    exp_regs[2] = 32'h7777_7777;
    @(posedge tb_ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    eb = exp_b_q.pop_front();
    checks++;
    if (BVALID !== 1'b1 || BRESP !== eb) begin
      errors++; $display("FAIL rel_commit got=%b/%b exp=1/%b", BVALID, BRESP, eb);
    end
    @(posedge tb_ACLK); #1;
    for (int i = 0; i < NREG; i++) begin
      exp_r_q.push_back({OKAY, (i == 7) ? status_in[255:224] : exp_regs[i]});
      axi_read(6'(4*i), got);
      er = exp_r_q.pop_front();
      checks++;
      if (got !== er) begin errors++; $display("FAIL abort_read%0d got=%h exp=%h", i, got, er); end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_strobe();
    test_read_only();
    test_out_of_range();
    test_back_to_back();
    test_reset_abort();
    repeat (2) @(posedge tb_ACLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
